// File: rtl/maze_solve_if.sv
// maze_solve_if: handshake bundle between the maze sequencer and its environment.
// master drives the solve request, navigate status and IR/magnet sensor inputs;
// slave is the maze_solve sequencer, which drives the navigate command outputs.
interface maze_solve_if;
  logic        strt_solve;
  logic        lft_affinity;
  logic        mv_cmplt;
  logic        lft_opn;
  logic        rght_opn;
  logic        frwrd_opn;
  logic        sol_cmplt;
  logic        strt_hdng;
  logic        strt_mv;
  logic        stp_lft;
  logic        stp_rght;
  logic [11:0] dsrd_hdng;
  logic        solving;
  logic        done;

  modport master (
    output strt_solve, lft_affinity, mv_cmplt, lft_opn, rght_opn, frwrd_opn, sol_cmplt,
    input  strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng, solving, done
  );

  modport slave (
    input  strt_solve, lft_affinity, mv_cmplt, lft_opn, rght_opn, frwrd_opn, sol_cmplt,
    output strt_hdng, strt_mv, stp_lft, stp_rght, dsrd_hdng, solving, done
  );
endinterface

// File: rtl/maze_solve.sv
// maze_solve: wall-following sequencer driving the navigate block.
// After every completed heading change or forward move it picks the next step
// (affinity-side turn, forward, opposite turn, or U-turn) and stops once the
// magnet sensor has reported the solution point.
// Optional build macro MAZE_SOLVE_UTURN180_EN: dead ends are issued as one
// 180-degree heading command instead of two right-angle turns.
module maze_solve (
  input  logic       clk,
  input  logic       rst_n,
  maze_solve_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECIDE    = 3'd1,
    ISSUE_HDG = 3'd2,
    WAIT_HDG  = 3'd3,
    ISSUE_MV  = 3'd4,
    WAIT_MV   = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] dir_q, dir_d;          // 0=N 1=W 2=S 3=E
  logic       aff_q, aff_d;          // 1 = left-wall follower
  logic       sol_lat_q, sol_lat_d;
  logic       uturn_pend_q, uturn_pend_d;
  logic       side_open, opp_open, active;

  // One right-angle step; left turns increase the index, wrap is 2-bit overflow.
  function automatic logic [1:0] turn(input logic [1:0] dir, input logic left);
    return left ? dir + 2'd1 : dir - 2'd1;
  endfunction

  function automatic logic [11:0] hdg_code(input logic [1:0] dir);
    case (dir)
      2'd0:    return 12'h000;
      2'd1:    return 12'h3FF;
      2'd2:    return 12'h7FF;
      default: return 12'hC00;
    endcase
  endfunction

  assign side_open = aff_q ? bus.lft_opn  : bus.rght_opn;
  assign opp_open  = aff_q ? bus.rght_opn : bus.lft_opn;
  assign active    = (state_q != IDLE) && (state_q != DONE);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 2'd0;
      aff_q        <= 1'b0;
      sol_lat_q    <= 1'b0;
      uturn_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      aff_q        <= aff_d;
      sol_lat_q    <= sol_lat_d;
      uturn_pend_q <= uturn_pend_d;
    end
  end

  // Next-state and decision logic; openings only matter in DECIDE
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    aff_d        = aff_q;
    sol_lat_d    = sol_lat_q;
    uturn_pend_d = uturn_pend_q;
    // The magnet flag may arrive mid-move; remember it until the move ends.
    if (active && bus.sol_cmplt) sol_lat_d = 1'b1;
    case (state_q)
      IDLE, DONE: begin
        if (bus.strt_solve) begin
          aff_d        = bus.lft_affinity;
          sol_lat_d    = 1'b0;
          uturn_pend_d = 1'b0;
          state_d      = ISSUE_MV;
        end
      end
      ISSUE_MV: state_d = WAIT_MV;
      WAIT_MV: begin
        if (bus.mv_cmplt) state_d = (sol_lat_q || bus.sol_cmplt) ? DONE : DECIDE;
      end
      DECIDE: begin
        if (side_open) begin
          dir_d   = turn(dir_q, aff_q);
          state_d = ISSUE_HDG;
        end else if (bus.frwrd_opn) begin
          state_d = ISSUE_MV;
        end else if (opp_open) begin
          dir_d   = turn(dir_q, ~aff_q);
          state_d = ISSUE_HDG;
        end else begin
`ifdef MAZE_SOLVE_UTURN180_EN
          dir_d        = dir_q + 2'd2;
`else
          // Dead end: first of two right-angle turns toward the affinity side.
          dir_d        = turn(dir_q, aff_q);
          uturn_pend_d = 1'b1;
`endif
          state_d = ISSUE_HDG;
        end
      end
      ISSUE_HDG: state_d = WAIT_HDG;
      WAIT_HDG: begin
        if (bus.mv_cmplt) begin
          if (uturn_pend_q) begin
            dir_d        = turn(dir_q, aff_q);
            uturn_pend_d = 1'b0;
            state_d      = ISSUE_HDG;
          end else if (sol_lat_q) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE_MV;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so strobes are glitch-free
  always_comb begin
    bus.strt_hdng = (state_q == ISSUE_HDG);
    bus.strt_mv   = (state_q == ISSUE_MV);
    bus.solving   = active;
    bus.done      = (state_q == DONE);
    bus.stp_lft   = active & aff_q;
    bus.stp_rght  = active & ~aff_q;
    bus.dsrd_hdng = hdg_code(dir_q);
  end

endmodule

// File: tb/tb_maze_solve.sv
// tb_maze_solve: directed scenarios plus a randomized maze walk, checked
// against a heading/decision model kept in the bench.
module tb_maze_solve;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_solve_if bus();
  maze_solve dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: heading index, affinity, pending second turn, latched solution
  int   m_dir;
  logic m_aff, m_sol, m_pend;
  int   m_phase;              // 0 = a forward move is in flight, 1 = a heading change
  localparam int PH_MV = 0, PH_HDG = 1;

  function automatic logic [11:0] hdg_of(input int d);
    case (d % 4)
      0:       return 12'h000;
      1:       return 12'h3FF;
      2:       return 12'h7FF;
      default: return 12'hC00;
    endcase
  endfunction

  // Model of one decision after a forward move; returns which command is expected
  task automatic model_decide(input logic l, input logic r, input logic f,
                              output logic e_sh, output logic e_sm);
    logic a_open, o_open;
    int toward, away;
    a_open = m_aff ? l : r;
    o_open = m_aff ? r : l;
    toward = m_aff ? 1 : 3;
    away   = m_aff ? 3 : 1;
    e_sh = 1'b1; e_sm = 1'b0;
    if (a_open) m_dir = (m_dir + toward) % 4;
    else if (f) begin e_sh = 1'b0; e_sm = 1'b1; end
    else if (o_open) m_dir = (m_dir + away) % 4;
    else begin
`ifdef MAZE_SOLVE_UTURN180_EN
      m_dir = (m_dir + 2) % 4;
`else
      m_dir  = (m_dir + toward) % 4;
      m_pend = 1'b1;
`endif
    end
  endtask

  task automatic rand_flags();
    bus.lft_opn   = 1'($urandom);
    bus.rght_opn  = 1'($urandom);
    bus.frwrd_opn = 1'($urandom);
  endtask

  // Pulse strt_solve; report strt_mv in the next cycle and any strobe one cycle after
  task automatic start_solve(input logic aff, output logic sm, output logic extra);
    bus.strt_solve = 1'b1; bus.lft_affinity = aff;
    @(posedge clk); #1;
    bus.strt_solve = 1'b0; bus.lft_affinity = 1'($urandom);
    @(negedge clk); sm = bus.strt_mv;
    @(posedge clk); #1;
    @(negedge clk); extra = bus.strt_mv | bus.strt_hdng;
    @(posedge clk); #1;
  endtask

  // Pulse mv_cmplt with the given openings; report first strobe within 4 cycles
  task automatic complete(input logic l, input logic r, input logic f, input logic sol,
                          output int lat, output logic sh, output logic sm,
                          output logic [11:0] hd, output logic extra);
    bus.lft_opn = l; bus.rght_opn = r; bus.frwrd_opn = f;
    bus.sol_cmplt = sol; bus.mv_cmplt = 1'b1;
    @(posedge clk); #1;
    bus.mv_cmplt = 1'b0; bus.sol_cmplt = 1'b0;
    lat = 0; sh = 1'b0; sm = 1'b0; hd = 12'h000; extra = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (lat == 0) begin
        @(negedge clk);
        if (bus.strt_hdng || bus.strt_mv) begin
          lat = i; sh = bus.strt_hdng; sm = bus.strt_mv; hd = bus.dsrd_hdng;
        end else begin
          @(posedge clk); #1;
          if (i == 1) rand_flags();
        end
      end
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      @(negedge clk); extra = bus.strt_hdng | bus.strt_mv;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.strt_solve = 0; bus.lft_affinity = 0; bus.mv_cmplt = 0; bus.sol_cmplt = 0;
    bus.lft_opn = 0; bus.rght_opn = 0; bus.frwrd_opn = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.strt_hdng, bus.strt_mv, bus.stp_lft, bus.stp_rght, bus.solving, bus.done} !== 6'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 000000",
        {bus.strt_hdng, bus.strt_mv, bus.stp_lft, bus.stp_rght, bus.solving, bus.done});
    end
    n_cmp++;
    if (bus.dsrd_hdng !== 12'h000) begin
      n_err++; $display("FAIL reset_hdng: got %h want 000", bus.dsrd_hdng);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.solving !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: solving=%b done=%b want 0 0", bus.solving, bus.done);
    end
    @(posedge clk); #1;
    m_dir = 0; m_pend = 0; m_sol = 0;
  endtask

  task automatic test_start_left();
    logic sm, ex;
    start_solve(1'b1, sm, ex);
    m_aff = 1'b1; m_phase = PH_MV;
    n_cmp++;
    if (sm !== 1'b1) begin n_err++; $display("FAIL start_strt_mv: got %b want 1", sm); end
    n_cmp++;
    if (ex !== 1'b0) begin n_err++; $display("FAIL start_strobe_width: got %b want 0", ex); end
    n_cmp++;
    if ({bus.stp_lft, bus.stp_rght, bus.solving} !== 3'b101) begin
      n_err++; $display("FAIL start_stp_left: got %b want 101", {bus.stp_lft, bus.stp_rght, bus.solving});
    end
  endtask

  task automatic test_left_open();
    int lat; logic sh, sm, ex; logic [11:0] hd;
    complete(1'b1, 1'b0, 1'b1, 1'b0, lat, sh, sm, hd, ex);
    n_cmp++;
    if (lat !== 2 || sh !== 1'b1 || sm !== 1'b0 || hd !== 12'h3FF || ex !== 1'b0) begin
      n_err++; $display("FAIL left_open_turn: lat=%0d sh=%b sm=%b hd=%h ex=%b want 2 1 0 3ff 0", lat, sh, sm, hd, ex);
    end
    complete(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, lat, sh, sm, hd, ex);
    n_cmp++;
    if (lat !== 1 || sm !== 1'b1 || sh !== 1'b0 || hd !== 12'h3FF) begin
      n_err++; $display("FAIL left_open_move: lat=%0d sh=%b sm=%b hd=%h want 1 0 1 3ff", lat, sh, sm, hd);
    end
  endtask

  task automatic test_right_forward();
    int lat; logic sh, sm, ex; logic [11:0] hd;
    // Reset while solving returns everything, including the heading, to reset values
    rst_n = 1'b0; #1;
    n_cmp++;
    if (bus.solving !== 1'b0 || bus.dsrd_hdng !== 12'h000) begin
      n_err++; $display("FAIL midop_reset: solving=%b hd=%h want 0 000", bus.solving, bus.dsrd_hdng);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    m_dir = 0;
    start_solve(1'b0, sm, ex);
    m_aff = 1'b0;
    n_cmp++;
    if (sm !== 1'b1 || bus.stp_lft !== 1'b0 || bus.stp_rght !== 1'b1) begin
      n_err++; $display("FAIL right_start: sm=%b stp_lft=%b stp_rght=%b want 1 0 1", sm, bus.stp_lft, bus.stp_rght);
    end
    complete(1'b0, 1'b0, 1'b1, 1'b0, lat, sh, sm, hd, ex);
    n_cmp++;
    if (lat !== 2 || sm !== 1'b1 || sh !== 1'b0 || hd !== 12'h000 || ex !== 1'b0) begin
      n_err++; $display("FAIL right_forward: lat=%0d sh=%b sm=%b hd=%h want 2 0 1 000", lat, sh, sm, hd);
    end
  endtask

  task automatic test_wrap();
    int lat; logic sh, sm, ex; logic [11:0] hd;
    logic [11:0] exp_tab [4];
    exp_tab[0] = 12'hC00; exp_tab[1] = 12'h7FF; exp_tab[2] = 12'h3FF; exp_tab[3] = 12'h000;
    for (int k = 0; k < 4; k++) begin
      complete(1'($urandom), 1'b1, 1'($urandom), 1'b0, lat, sh, sm, hd, ex);
      n_cmp++;
      if (lat !== 2 || sh !== 1'b1 || hd !== exp_tab[k]) begin
        n_err++; $display("FAIL wrap_turn%0d: lat=%0d sh=%b hd=%h want 2 1 %h", k, lat, sh, hd, exp_tab[k]);
      end
      complete(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, lat, sh, sm, hd, ex);
      n_cmp++;
      if (lat !== 1 || sm !== 1'b1) begin
        n_err++; $display("FAIL wrap_move%0d: lat=%0d sm=%b want 1 1", k, lat, sm);
      end
    end
    m_dir = 0;
  endtask

  task automatic test_solution();
    int lat; logic sh, sm, ex; logic [11:0] hd;
    // Turn right from N to face E, then move
    complete(1'b0, 1'b1, 1'b0, 1'b0, lat, sh, sm, hd, ex);
    complete(1'b0, 1'b0, 1'b0, 1'b0, lat, sh, sm, hd, ex);
    n_cmp++;
    if (lat !== 1 || sm !== 1'b1 || hd !== 12'hC00) begin
      n_err++; $display("FAIL sol_setup: lat=%0d sm=%b hd=%h want 1 1 c00", lat, sm, hd);
    end
    bus.sol_cmplt = 1'b1;
    @(posedge clk); #1;
    bus.sol_cmplt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.solving !== 1'b1 || bus.done !== 1'b0 || bus.strt_mv !== 1'b0 || bus.strt_hdng !== 1'b0) begin
      n_err++; $display("FAIL sol_midmove: solving=%b done=%b want 1 0", bus.solving, bus.done);
    end
    @(posedge clk); #1;
    complete(1'b1, 1'b1, 1'b1, 1'b0, lat, sh, sm, hd, ex);
    n_cmp++;
    if (lat !== 0 || bus.done !== 1'b1 || bus.solving !== 1'b0 || bus.stp_lft !== 1'b0 || bus.stp_rght !== 1'b0) begin
      n_err++; $display("FAIL sol_done: lat=%0d done=%b solving=%b stp=%b%b want 0 1 0 00",
        lat, bus.done, bus.solving, bus.stp_lft, bus.stp_rght);
    end
    complete(1'b1, 1'b0, 1'b1, 1'b0, lat, sh, sm, hd, ex);
    n_cmp++;
    if (lat !== 0 || bus.done !== 1'b1) begin
      n_err++; $display("FAIL done_ignores_cmplt: lat=%0d done=%b want 0 1", lat, bus.done);
    end
    start_solve(1'b1, sm, ex);
    m_aff = 1'b1; m_dir = 3; m_sol = 0; m_pend = 0; m_phase = PH_MV;
    n_cmp++;
    if (sm !== 1'b1 || bus.done !== 1'b0 || bus.stp_lft !== 1'b1) begin
      n_err++; $display("FAIL restart: sm=%b done=%b stp_lft=%b want 1 0 1", sm, bus.done, bus.stp_lft);
    end
  endtask

  task automatic test_dead_end();
    int lat; logic sh, sm, ex; logic [11:0] hd;
    complete(1'b0, 1'b0, 1'b0, 1'b0, lat, sh, sm, hd, ex);
`ifdef MAZE_SOLVE_UTURN180_EN
    n_cmp++;
    if (lat !== 2 || sh !== 1'b1 || hd !== 12'h3FF) begin
      n_err++; $display("FAIL dead_end_180: lat=%0d sh=%b hd=%h want 2 1 3ff", lat, sh, hd);
    end
`else
    n_cmp++;
    if (lat !== 2 || sh !== 1'b1 || hd !== 12'h000) begin
      n_err++; $display("FAIL dead_end_first: lat=%0d sh=%b hd=%h want 2 1 000", lat, sh, hd);
    end
    complete(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, lat, sh, sm, hd, ex);
    n_cmp++;
    if (lat !== 1 || sh !== 1'b1 || sm !== 1'b0 || hd !== 12'h3FF) begin
      n_err++; $display("FAIL dead_end_second: lat=%0d sh=%b sm=%b hd=%h want 1 1 0 3ff", lat, sh, sm, hd);
    end
`endif
    complete(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, lat, sh, sm, hd, ex);
    n_cmp++;
    if (lat !== 1 || sm !== 1'b1 || hd !== 12'h3FF) begin
      n_err++; $display("FAIL dead_end_move: lat=%0d sm=%b hd=%h want 1 1 3ff", lat, sm, hd);
    end
    m_dir = 1; m_phase = PH_MV;
  endtask

  task automatic test_random_walk();
    int lat, e_lat; logic sh, sm, ex, e_sh, e_sm, e_done, sw, l, r, f; logic [11:0] hd;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        bus.sol_cmplt = 1'b1;
        @(posedge clk); #1;
        bus.sol_cmplt = 1'b0;
        m_sol = 1'b1;
      end
      l = 1'($urandom); r = 1'($urandom); f = 1'($urandom);
      sw = ($urandom_range(0, 7) == 0);
      e_sh = 0; e_sm = 0; e_done = 0; e_lat = 0;
      if (m_phase == PH_MV) begin
        if (m_sol || sw) e_done = 1'b1;
        else begin model_decide(l, r, f, e_sh, e_sm); e_lat = 2; end
      end else begin
        e_lat = 1;
        if (m_pend) begin
          m_pend = 1'b0; m_dir = (m_dir + (m_aff ? 1 : 3)) % 4; e_sh = 1'b1;
        end else if (m_sol) begin
          e_done = 1'b1; e_lat = 0;
        end else e_sm = 1'b1;
        m_sol = m_sol | sw;
      end
      complete(l, r, f, sw, lat, sh, sm, hd, ex);
      n_cmp++;
      if (lat !== e_lat || sh !== e_sh || sm !== e_sm || ex !== 1'b0 ||
          (lat != 0 && hd !== hdg_of(m_dir))) begin
        n_err++; $display("FAIL rand_step%0d: lat=%0d sh=%b sm=%b hd=%h ex=%b want %0d %b %b %h 0",
          it, lat, sh, sm, hd, ex, e_lat, e_sh, e_sm, hdg_of(m_dir));
      end
      if (e_done) begin
        n_cmp++;
        if (bus.done !== 1'b1 || bus.solving !== 1'b0 || bus.stp_lft !== 1'b0 || bus.stp_rght !== 1'b0) begin
          n_err++; $display("FAIL rand_done%0d: done=%b solving=%b want 1 0", it, bus.done, bus.solving);
        end
        m_aff = 1'($urandom);
        start_solve(m_aff, sm, ex);
        m_sol = 1'b0; m_pend = 1'b0; m_phase = PH_MV;
        n_cmp++;
        if (sm !== 1'b1 || ex !== 1'b0) begin
          n_err++; $display("FAIL rand_restart%0d: sm=%b ex=%b want 1 0", it, sm, ex);
        end
      end else begin
        m_phase = e_sh ? PH_HDG : PH_MV;
      end
      n_cmp++;
      if (bus.stp_lft !== m_aff || bus.stp_rght !== ~m_aff) begin
        n_err++; $display("FAIL rand_stp%0d: stp_lft=%b stp_rght=%b aff=%b", it, bus.stp_lft, bus.stp_rght, m_aff);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_left();
    test_left_open();
    test_right_forward();
    test_wrap();
    test_solution();
    test_dead_end();
    test_random_walk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
